snow64_icache_line_filler: RTL and testbench
============================================

// Module: snow64_icache_line_filler
// PURPOSE
// - Memory-side stage directly downstream of the instruction cache: takes a one-cycle line-miss request (req, addr).
// - Fetches the enclosing cache line from a narrower memory bus in LINE/BUS back-to-back beats, assembling each beat into a line buffer.
// - Returns the full line with a one-cycle valid pulse, as the cache's wait-for-memory state expects.
// PARAMETERS
// - WIDTH_ADDR  64   CPU address width (`WIDTH__SNOW64_CPU_ADDR)
// - WIDTH_LINE  256  icache line width (`WIDTH__SNOW64_ICACHE_LINE_DATA)
// - WIDTH_BUS   64   memory bus data width; WIDTH_LINE % WIDTH_BUS == 0, both powers of two
// PORTS
// - clk              in   1           clock, all state on posedge
// - rst_n            in   1           asynchronous active-low reset
// - in_fill.req      in   1           line-fill request (cache mem-access req)
// - in_fill.addr     in   WIDTH_ADDR  any byte address inside the wanted line
// - out_fill.valid   out  1           one-cycle pulse: out_fill.data holds the requested line
// - out_fill.data    out  WIDTH_LINE  assembled line, beat k at [k*WIDTH_BUS +: WIDTH_BUS]
// - out_bus.req      out  1           bus read request, held until acked
// - out_bus.addr     out  WIDTH_ADDR  beat byte address, low log2(WIDTH_BUS/8) bits zero
// - in_bus.ack       in   1           beat accepted; in_bus.data valid this same cycle
// - in_bus.data      in   WIDTH_BUS   beat read data
// - out_busy         out  1           high while in StBusRead
// BEHAVIOUR
// - Constants:
//   - NUM_BEATS = WIDTH_LINE/WIDTH_BUS (4 by default).
//   - Line offset bits = log2(WIDTH_LINE/8) (5). Beat offset bits = log2(WIDTH_BUS/8) (3).
// - Reset (async, rst_n=0):
//   - State StIdle; beat counter 0; captured base 0; line buffer 0.
//   - All outputs 0.
//   - Reset mid-fill abandons the fill. No valid is produced for it, and bus req drops during reset.
// - StIdle:
//   - out_bus.req=0.
//   - On in_fill.req=1, capture base = in_fill.addr with line-offset bits zeroed, set beat=0, go to StBusRead.
//   - At that same edge drive out_bus.req<=1 and out_bus.addr<=base.
// - StBusRead:
//   - out_bus.req stays 1 and out_bus.addr stays stable until in_bus.ack.
//   - On an ack edge, line[beat*WIDTH_BUS +: WIDTH_BUS] <= in_bus.data.
//   - Non-final beat: beat<=beat+1 and out_bus.addr<=base+(beat+1)*(WIDTH_BUS/8). Req stays high, so there is no idle cycle between beats.
//   - Final beat (beat==NUM_BEATS-1): out_bus.req<=0, out_fill.valid<=1, go to StIdle.
// - Beat counter is log2(NUM_BEATS) bits wide. Address arithmetic is WIDTH_ADDR wide and never carries out of the line, since base is aligned.
// - out_fill.valid:
//   - High exactly one cycle, the cycle after the final ack; 0 in every other cycle.
//   - out_fill.data is the line register. It is stable from the valid cycle until the next fill's first ack.
// - Latency: 1 + NUM_BEATS + (sum of ack wait cycles) from the req edge to valid. Zero-wait bus with 4 beats gives valid 5 cycles after the req cycle.
// - in_fill.req while in StBusRead: ignored, and no queueing. A simulation-only assertion flags it as a protocol violation.
// - in_fill.req in the valid cycle (state already StIdle): accepted normally and a new fill starts.
// - in_bus.ack while out_bus.req=0: ignored, with no effect on line or state.
// - Wrap-around: an address near 2^64-1 has its base aligned down, so there is no overflow.
// STRUCTURE
// - Package PkgSnow64IcacheLineFiller holds:
//   - enum State {StIdle, StBusRead};
//   - packed structs PortIn_Fill{req,addr}, PortOut_Fill{valid,data}, PortOut_Bus{req,addr}, PortIn_Bus{ack,data};
//   - localparams for NUM_BEATS, offset widths and beat-counter MSB.
// - PortIn_Fill / PortOut_Fill are field-compatible with the cache's mem-access structs, so they connect directly.
// - Single flat module; no sub-module is warranted. Beat insertion uses an indexed part-select, not a generated case.
// TESTING
// 1. Reset, then check all outputs are 0. Req addr=64'h1234 with zero-wait bus returning beats 64'hA0..A3 -> bus addrs 1220,1228,1230,1238; valid exactly in cycle 5; data={A3,A2,A1,A0}.
// 2. Ack stalls of 0,3,0,2 cycles on addr 64'h40 -> out_bus.addr holds per beat; req never drops mid-line; valid 10 cycles after req; single pulse.
// 3. Second in_fill.req (addr 64'h80) during beat 2 -> ignored; bus addrs continue on the 64'h40 line; assertion fires.
// 4. New req (addr 64'h100) in the valid cycle of the previous fill -> next cycle out_bus.addr=64'h100, out_busy=1; previous data held until the first ack.
// 5. rst_n low after beat 1 ack, then high -> no valid pulse; outputs 0; a fresh req to 64'hFFFF_FFFF_FFFF_FFFC fetches from base 64'hFFFF_FFFF_FFFF_FFE0.
// 6. Spurious in_bus.ack=1, data=64'hDEAD while idle -> line and outputs unchanged.

Source files
------------

// File: rtl/snow64_icache_line_filler_pkg.sv
// snow64_icache_line_filler_pkg: shared types and default geometry for the icache line filler
// Holds the FSM state enum, the fill/bus port structs and the default widths and offsets.
package snow64_icache_line_filler_pkg;

    localparam int DEF_WIDTH_ADDR = 64;
    localparam int DEF_WIDTH_LINE = 256;
    localparam int DEF_WIDTH_BUS = 64;
    localparam int NUM_BEATS = DEF_WIDTH_LINE / DEF_WIDTH_BUS;
    localparam int LINE_OFF_BITS = $clog2(DEF_WIDTH_LINE / 8);
    localparam int BEAT_OFF_BITS = $clog2(DEF_WIDTH_BUS / 8);
    localparam int BEAT_MSB = (NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1) - 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUS_READ
    } state_t;

    // Field-compatible with the cache's mem-access request/response structs.
    typedef struct packed {
        logic req;
        logic [DEF_WIDTH_ADDR-1:0] addr;
    } fill_in_t;

    typedef struct packed {
        logic valid;
        logic [DEF_WIDTH_LINE-1:0] data;
    } fill_out_t;

    typedef struct packed {
        logic req;
        logic [DEF_WIDTH_ADDR-1:0] addr;
    } bus_out_t;

    typedef struct packed {
        logic ack;
        logic [DEF_WIDTH_BUS-1:0] data;
    } bus_in_t;

endpackage

// File: rtl/snow64_icache_line_filler.sv
// snow64_icache_line_filler: fetches an icache line as back-to-back narrow bus beats
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fill_req, fill_addr   one-cycle line-miss request, any byte address inside the line
//   fill_valid, fill_data one-cycle pulse with the assembled line (beat k at [k*WIDTH_BUS +: WIDTH_BUS])
//   bus_req, bus_addr     beat read request held until acked, beat-aligned byte address
//   bus_ack, bus_data     beat accepted, read data valid in the same cycle
//   busy                  high while beats are being fetched
module snow64_icache_line_filler
    import snow64_icache_line_filler_pkg::*;
#(
    parameter int WIDTH_ADDR = DEF_WIDTH_ADDR,
    parameter int WIDTH_LINE = DEF_WIDTH_LINE,
    parameter int WIDTH_BUS = DEF_WIDTH_BUS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_req,
    input  logic [WIDTH_ADDR-1:0] fill_addr,
    output logic                  fill_valid,
    output logic [WIDTH_LINE-1:0] fill_data,
    output logic                  bus_req,
    output logic [WIDTH_ADDR-1:0] bus_addr,
    input  logic                  bus_ack,
    input  logic [WIDTH_BUS-1:0]  bus_data,
    output logic                  busy
);

    localparam int NB = WIDTH_LINE / WIDTH_BUS;
    localparam int LO = $clog2(WIDTH_LINE / 8);
    localparam int BO = $clog2(WIDTH_BUS / 8);
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [WIDTH_ADDR-1:0] LINE_MASK = ~((WIDTH_ADDR'(1) << LO) - WIDTH_ADDR'(1));

    state_t state, state_next;
    logic [WIDTH_ADDR-1:0] base;
    logic [BW-1:0] beat;
    logic [WIDTH_LINE-1:0] line;
    logic valid;
    logic rd, last;

    assign rd = state == ST_BUS_READ;
    assign last = beat == BW'(NB - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_IDLE)
            state_next = fill_req ? ST_BUS_READ : ST_IDLE;
        else
            state_next = bus_ack && last ? ST_IDLE : ST_BUS_READ;
    end

    // Bus request is exactly the read state, so it drops at once on reset and never gaps between beats.
    always_comb begin
        busy = rd;
        bus_req = rd;
        bus_addr = base + (WIDTH_ADDR'(beat) << BO);
        fill_valid = valid;
        fill_data = line;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            beat <= '0;
            line <= '0;
            valid <= 1'b0;
        end else begin
            valid <= rd && bus_ack && last;
            if (state == ST_IDLE && fill_req) begin
                base <= fill_addr & LINE_MASK;
                beat <= '0;
            end else if (rd && bus_ack) begin
                line[beat*WIDTH_BUS +: WIDTH_BUS] <= bus_data;
                beat <= beat + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // A new request while fetching is dropped, not queued; flag it for the cache designer.
    always @(posedge clk) begin
        if (rst_n && rd)
            assert (!fill_req) else $warning("fill request while busy is dropped");
    end
`endif

endmodule

// File: tb/tb_snow64_icache_line_filler.sv
// tb_snow64_icache_line_filler: directed self-checking bench for the icache line filler
module tb_snow64_icache_line_filler;

    logic clk;
    logic rst_n;
    logic fill_req;
    logic [63:0] fill_addr;
    logic fill_valid;
    logic [255:0] fill_data;
    logic bus_req;
    logic [63:0] bus_addr;
    logic bus_ack;
    logic [63:0] bus_data;
    logic busy;

    int errors;
    int checks;

    snow64_icache_line_filler dut (
        .clk(clk),
        .rst_n(rst_n),
        .fill_req(fill_req),
        .fill_addr(fill_addr),
        .fill_valid(fill_valid),
        .fill_data(fill_data),
        .bus_req(bus_req),
        .bus_addr(bus_addr),
        .bus_ack(bus_ack),
        .bus_data(bus_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        fill_req = 1'b0;
        fill_addr = '0;
        bus_ack = 1'b0;
        bus_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fill_valid, bus_req, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got valid/req/busy=%b expected 000", {fill_valid, bus_req, busy});
        end
        checks++;
        if (fill_data !== 256'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", fill_data);
        end
        checks++;
        if (bus_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", bus_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        fill_req = 1'b1;
        fill_addr = 64'h1234;
        @(negedge clk);
        fill_req = 1'b0;
        cyc = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== 64'h1220 + 64'(8 * k) || fill_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                         k, bus_req, bus_addr, fill_valid, 64'h1220 + 64'(8 * k));
            end
            bus_ack = 1'b1;
            bus_data = 64'hA0 + 64'(k);
            @(negedge clk);
            cyc++;
        end
        bus_ack = 1'b0;
        checks++;
        if (fill_valid !== 1'b1 || cyc != 5) begin
            errors++;
            $display("FAIL basic_valid: got valid=%b at cycle %0d expected 1 at cycle 5", fill_valid, cyc);
        end
        checks++;
        if (fill_data !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin
            errors++;
            $display("FAIL basic_data: got %h expected A3..A0 line", fill_data);
        end
        @(negedge clk);
        checks++;
        if (fill_valid !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: got valid=%b busy=%b req=%b expected 0 0 0", fill_valid, busy, bus_req);
        end
    endtask

    task automatic test_stalls();
        int st [4] = '{0, 3, 0, 2};
        int cyc;
        int pulses;
        fill_req = 1'b1;
        fill_addr = 64'h40;
        @(negedge clk);
        fill_req = 1'b0;
        cyc = 1;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s <= st[k]; s++) begin
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== 64'h40 + 64'(8 * k) || fill_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_beat%0d_wait%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                             k, s, bus_req, bus_addr, fill_valid, 64'h40 + 64'(8 * k));
                end
                bus_ack = s == st[k];
                bus_data = 64'hB0 + 64'(k);
                @(negedge clk);
                cyc++;
            end
        end
        bus_ack = 1'b0;
        checks++;
        if (fill_valid !== 1'b1 || cyc != 10) begin
            errors++;
            $display("FAIL stall_valid: got valid=%b at cycle %0d expected 1 at cycle 10", fill_valid, cyc);
        end
        checks++;
        if (fill_data !== {64'hB3, 64'hB2, 64'hB1, 64'hB0}) begin
            errors++;
            $display("FAIL stall_data: got %h expected B3..B0 line", fill_data);
        end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(fill_valid);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL stall_single_pulse: got %0d extra valid cycles expected 0", pulses);
        end
    endtask

    task automatic test_busy_req();
        fill_req = 1'b1;
        fill_addr = 64'h40;
        @(negedge clk);
        fill_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                fill_req = 1'b1;
                fill_addr = 64'h80;
                bus_ack = 1'b0;
                @(negedge clk);
                fill_req = 1'b0;
            end
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== 64'h40 + 64'(8 * k)) begin
                errors++;
                $display("FAIL busyreq_beat%0d: got req=%b addr=%h expected req=1 addr=%h",
                         k, bus_req, bus_addr, 64'h40 + 64'(8 * k));
            end
            bus_ack = 1'b1;
            bus_data = 64'hC0 + 64'(k);
            @(negedge clk);
        end
        bus_ack = 1'b0;
        checks++;
        if (fill_valid !== 1'b1 || fill_data !== {64'hC3, 64'hC2, 64'hC1, 64'hC0}) begin
            errors++;
            $display("FAIL busyreq_result: got valid=%b data=%h expected 1 and C3..C0 line", fill_valid, fill_data);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL busyreq_no_queue: got busy=%b req=%b expected 0 0", busy, bus_req);
        end
    endtask

    task automatic test_back_to_back();
        fill_req = 1'b1;
        fill_addr = 64'h200;
        @(negedge clk);
        fill_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_ack = 1'b1;
            bus_data = 64'hD0 + 64'(k);
            @(negedge clk);
        end
        bus_ack = 1'b0;
        checks++;
        if (fill_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_valid: got %b expected 1", fill_valid);
        end
        fill_req = 1'b1;
        fill_addr = 64'h100;
        @(negedge clk);
        fill_req = 1'b0;
        checks++;
        if (bus_addr !== 64'h100 || busy !== 1'b1 || bus_req !== 1'b1 || fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start: got addr=%h busy=%b req=%b valid=%b expected 100 1 1 0",
                     bus_addr, busy, bus_req, fill_valid);
        end
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (fill_data !== {64'hD3, 64'hD2, 64'hD1, 64'hD0}) begin
                errors++;
                $display("FAIL b2b_hold%0d: got %h expected D3..D0 line", s, fill_data);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            bus_ack = 1'b1;
            bus_data = 64'hE0 + 64'(k);
            @(negedge clk);
        end
        bus_ack = 1'b0;
        checks++;
        if (fill_valid !== 1'b1 || fill_data !== {64'hE3, 64'hE2, 64'hE1, 64'hE0}) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b data=%h expected 1 and E3..E0 line", fill_valid, fill_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int pulses;
        fill_req = 1'b1;
        fill_addr = 64'h300;
        @(negedge clk);
        fill_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus_ack = 1'b1;
            bus_data = 64'h11 * 64'(k + 1);
            @(negedge clk);
        end
        bus_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got req=%b busy=%b expected 0 0", bus_req, busy);
        end
        @(negedge clk);
        checks++;
        if (fill_valid !== 1'b0 || fill_data !== 256'h0 || bus_addr !== 64'h0) begin
            errors++;
            $display("FAIL rst_outputs: got valid=%b data=%h addr=%h expected all 0", fill_valid, fill_data, bus_addr);
        end
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(fill_valid) + int'(bus_req);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rst_no_valid: got %0d valid/req cycles expected 0", pulses);
        end
        fill_req = 1'b1;
        fill_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        fill_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus_addr !== 64'hFFFF_FFFF_FFFF_FFE0 + 64'(8 * k)) begin
                errors++;
                $display("FAIL wrap_beat%0d: got addr=%h expected %h",
                         k, bus_addr, 64'hFFFF_FFFF_FFFF_FFE0 + 64'(8 * k));
            end
            bus_ack = 1'b1;
            bus_data = 64'hF0 + 64'(k);
            @(negedge clk);
        end
        bus_ack = 1'b0;
        checks++;
        if (fill_valid !== 1'b1 || fill_data !== {64'hF3, 64'hF2, 64'hF1, 64'hF0}) begin
            errors++;
            $display("FAIL wrap_result: got valid=%b data=%h expected 1 and F3..F0 line", fill_valid, fill_data);
        end
        @(negedge clk);
    endtask

    task automatic test_spurious_ack();
        bus_ack = 1'b1;
        bus_data = 64'hDEAD;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (fill_valid !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0 ||
                fill_data !== {64'hF3, 64'hF2, 64'hF1, 64'hF0}) begin
                errors++;
                $display("FAIL spurious%0d: got valid=%b busy=%b req=%b data=%h expected 0 0 0 and F3..F0 line",
                         s, fill_valid, busy, bus_req, fill_data);
            end
        end
        bus_ack = 1'b0;
        fill_req = 1'b1;
        fill_addr = 64'h500;
        @(negedge clk);
        fill_req = 1'b0;
        checks++;
        if (bus_addr !== 64'h500 || bus_req !== 1'b1) begin
            errors++;
            $display("FAIL spurious_next_fill: got addr=%h req=%b expected 500 1", bus_addr, bus_req);
        end
        for (int k = 0; k < 4; k++) begin
            bus_ack = 1'b1;
            bus_data = 64'h50 + 64'(k);
            @(negedge clk);
        end
        bus_ack = 1'b0;
        checks++;
        if (fill_valid !== 1'b1 || fill_data !== {64'h53, 64'h52, 64'h51, 64'h50}) begin
            errors++;
            $display("FAIL spurious_next_result: got valid=%b data=%h expected 1 and 53..50 line", fill_valid, fill_data);
        end
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_stalls();
        test_busy_req();
        test_back_to_back();
        test_reset_mid_fill();
        test_spurious_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
